// File: rtl/simple_or_pkg.sv
// -----------------------------------------------------------------------------
// simple_or_pkg
//   Shared defaults for the simple_or primitive and its activity counter.
//   Contents:
//     SIMPLE_OR_WIDTH_DEF  default operand width
//     SIMPLE_OR_CNT_W_DEF  default activity counter width
//     cnt_t                activity counter word at the default width
//     CNT_MAX              saturation value of cnt_t (all ones)
// -----------------------------------------------------------------------------
package simple_or_pkg;

    localparam int SIMPLE_OR_WIDTH_DEF = 1;
    localparam int SIMPLE_OR_CNT_W_DEF = 16;

    typedef logic [SIMPLE_OR_CNT_W_DEF-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

endpackage : simple_or_pkg

// File: rtl/simple_or_sat_cnt.sv
// -----------------------------------------------------------------------------
// simple_or_sat_cnt
//   Generic saturating up-counter. Counts up by one on each rising clk edge
//   with inc high, stops at all ones, and is cleared synchronously by clr
//   (clr has priority over inc).
//   Ports:
//     clk  in   1  clock, rising edge
//     rst  in   1  asynchronous active-high reset, forces cnt to 0
//     inc  in   1  count enable
//     clr  in   1  synchronous clear
//     cnt  out  W  current count
// -----------------------------------------------------------------------------
module simple_or_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // All ones means saturated; the increment is suppressed so it never wraps.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d
        // unassigned, which would infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: reset is asynchronous, so rst sits in the sensitivity list and the
    // count is forced to 0 without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every register samples pre-edge values.
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : simple_or_sat_cnt

// File: rtl/simple_or.sv
// -----------------------------------------------------------------------------
// simple_or
//   Bitwise two-input OR with registered and monitoring outputs.
//   f is purely combinational (a | b) and independent of clk and rst.
//   Optional build macro: SIMPLE_OR_STATS_EN adds the hi_cnt port and its
//   saturating activity counter; without it the port and logic are absent.
//   Ports:
//     clk       in   1      clock, rising edge
//     rst       in   1      asynchronous active-high reset of all registers
//     a         in   WIDTH  operand A
//     b         in   WIDTH  operand B
//     clr       in   1      synchronous clear of f_sticky and hi_cnt
//     f         out  WIDTH  a | b
//     f_q       out  WIDTH  f delayed by one clock
//     f_sticky  out  WIDTH  per-bit OR of every f since reset or clear
//     hi_cnt    out  CNT_W  cycles with any f bit high (SIMPLE_OR_STATS_EN)
// -----------------------------------------------------------------------------
module simple_or
    import simple_or_pkg::*;
#(
    parameter int WIDTH = SIMPLE_OR_WIDTH_DEF,
    parameter int CNT_W = SIMPLE_OR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic [WIDTH-1:0] f_sticky
`ifdef SIMPLE_OR_STATS_EN
    ,
    output logic [CNT_W-1:0] hi_cnt
`endif
);

    logic [WIDTH-1:0] f_reg_q;
    logic [WIDTH-1:0] sticky_q;
    logic [WIDTH-1:0] sticky_d;

    // Core function: no clock, no reset, X on the inputs propagates as-is.
    assign f = a | b;

    // Clear wins over accumulate, so f in a clearing cycle is dropped.
    always_comb begin
        sticky_d = sticky_q | f;
        if (clr) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_reg_q  <= '0;
            sticky_q <= '0;
        end else begin
            f_reg_q  <= f;
            sticky_q <= sticky_d;
        end
    end

    assign f_q      = f_reg_q;
    assign f_sticky = sticky_q;

`ifdef SIMPLE_OR_STATS_EN
    // A cycle is "active" when any bit of f is high.
    simple_or_sat_cnt #(
        .W   (CNT_W)
    ) u_hi_cnt (
        .clk (clk),
        .rst (rst),
        .inc (|f),
        .clr (clr),
        .cnt (hi_cnt)
    );
`endif

endmodule : simple_or

// File: tb/tb_simple_or.sv
// -----------------------------------------------------------------------------
// tb_simple_or
//   Directed bench for simple_or: a WIDTH=1 instance, a WIDTH=8 / CNT_W=3
//   instance, and a standalone 3-bit simple_or_sat_cnt. The hi_cnt checks
//   are compiled in only with SIMPLE_OR_STATS_EN.
// -----------------------------------------------------------------------------
module tb_simple_or;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
    } vec_t;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       clr;

    logic       a1, b1, f1, f_q1, sticky1;
    logic [7:0] a8, b8, f8, f_q8, sticky8;
`ifdef SIMPLE_OR_STATS_EN
    logic [2:0] hi_cnt8;
    logic [0:0] hi_cnt1_unused;
    logic [2:0] hi_cnt1;
    assign hi_cnt1_unused = hi_cnt1[0:0];
`endif

    logic       cnt_inc;
    logic       cnt_clr;
    logic [2:0] cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t v1[4];
    vec_t v8[4];

    simple_or #(
        .WIDTH    (1),
        .CNT_W    (3)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .a        (a1),
        .b        (b1),
        .clr      (clr),
        .f        (f1),
        .f_q      (f_q1),
        .f_sticky (sticky1)
`ifdef SIMPLE_OR_STATS_EN
        ,
        .hi_cnt   (hi_cnt1)
`endif
    );

    simple_or #(
        .WIDTH    (8),
        .CNT_W    (3)
    ) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .a        (a8),
        .b        (b8),
        .clr      (clr),
        .f        (f8),
        .f_q      (f_q8),
        .f_sticky (sticky8)
`ifdef SIMPLE_OR_STATS_EN
        ,
        .hi_cnt   (hi_cnt8)
`endif
    );

    simple_or_sat_cnt #(
        .W   (3)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .cnt (cnt3)
    );

    // Clock stays low until enabled so the first tests run with no edges.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        clr = 1'b0; cnt_inc = 1'b0; cnt_clr = 1'b0;
        rst = 1'b0; clk_en = 1'b0;

        v1[0] = '{a: 8'h00, b: 8'h00, f: 8'h00};
        v1[1] = '{a: 8'h00, b: 8'h01, f: 8'h01};
        v1[2] = '{a: 8'h01, b: 8'h00, f: 8'h01};
        v1[3] = '{a: 8'h01, b: 8'h01, f: 8'h01};

        v8[0] = '{a: 8'hA5, b: 8'h5A, f: 8'hFF};
        v8[1] = '{a: 8'h0F, b: 8'h00, f: 8'h0F};
        v8[2] = '{a: 8'h30, b: 8'h06, f: 8'h36};
        v8[3] = '{a: 8'h00, b: 8'h00, f: 8'h00};

        // Reset state, no clock edge yet.
        #1 rst = 1'b1;
        #1;
        check("rst_f_q1",     32'(f_q1),    32'h0);
        check("rst_sticky1",  32'(sticky1), 32'h0);
        check("rst_f_q8",     32'(f_q8),    32'h0);
        check("rst_sticky8",  32'(sticky8), 32'h0);
        check("rst_cnt3",     32'(cnt3),    32'h0);
`ifdef SIMPLE_OR_STATS_EN
        check("rst_hi_cnt8",  32'(hi_cnt8), 32'h0);
`endif

        // Truth tables, clock idle and rst held high.
        for (int i = 0; i < 4; i++) begin
            a1 = v1[i].a[0];
            b1 = v1[i].b[0];
            #10;
            check($sformatf("tt1_%0d", i), 32'(f1), 32'(v1[i].f[0]));
        end
        for (int i = 0; i < 4; i++) begin
            a8 = v8[i].a;
            b8 = v8[i].b;
            #10;
            check($sformatf("tt8_%0d", i), 32'(f8), 32'(v8[i].f));
        end

        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        rst = 1'b0;
        #1 clk_en = 1'b1;
        @(negedge clk);

        // Registered path and sticky hold.
        a1 = 1'b1; b1 = 1'b0;
        @(negedge clk);
        check("reg_f_q1_hi",    32'(f_q1),    32'h1);
        check("reg_sticky1_hi", 32'(sticky1), 32'h1);
        a1 = 1'b0;
        @(negedge clk);
        check("reg_f_q1_lo",    32'(f_q1),    32'h0);
        check("reg_sticky1_hold", 32'(sticky1), 32'h1);
        check("reg_f1_lo",      32'(f1),      32'h0);

        // Clear colliding with an active input.
        a1 = 1'b1; clr = 1'b1;
        @(negedge clk);
        check("clr_sticky1",    32'(sticky1), 32'h0);
        check("clr_f_q1",       32'(f_q1),    32'h1);
        clr = 1'b0;
        @(negedge clk);
        check("clr_sticky1_ret", 32'(sticky1), 32'h1);

        // Asynchronous reset mid-cycle with registers nonzero.
        #2 rst = 1'b1;
        #1;
        check("arst_f_q1",    32'(f_q1),    32'h0);
        check("arst_sticky1", 32'(sticky1), 32'h0);
        check("arst_f1",      32'(f1),      32'h1);
        @(negedge clk);
        check("arst_hold_f_q1",    32'(f_q1),    32'h0);
        check("arst_hold_sticky1", 32'(sticky1), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("arst_rel_f_q1",    32'(f_q1),    32'h1);
        check("arst_rel_sticky1", 32'(sticky1), 32'h1);
        a1 = 1'b0;

        // 8-bit sticky accumulation.
        a8 = 8'h00; b8 = 8'h00; clr = 1'b1;
        @(negedge clk);
        check("w8_clr_sticky", 32'(sticky8), 32'h00);
        clr = 1'b0; a8 = 8'h0F;
        @(negedge clk);
        check("w8_sticky_0f", 32'(sticky8), 32'h0F);
        check("w8_f_q_0f",    32'(f_q8),    32'h0F);
        a8 = 8'hA5; b8 = 8'h5A;
        @(negedge clk);
        check("w8_sticky_ff", 32'(sticky8), 32'hFF);
        a8 = 8'h00; b8 = 8'h00;
        @(negedge clk);
        check("w8_sticky_hold", 32'(sticky8), 32'hFF);
        check("w8_f_q_00",      32'(f_q8),    32'h00);

        // Standalone 3-bit saturating counter.
        cnt_clr = 1'b1;
        @(negedge clk);
        check("cnt_clr0", 32'(cnt3), 32'h0);
        cnt_clr = 1'b0; cnt_inc = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("cnt_sat_%0d", i), 32'(cnt3), 32'((i > 7) ? 7 : i));
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        check("cnt_clr_vs_inc", 32'(cnt3), 32'h0);
        cnt_clr = 1'b0; cnt_inc = 1'b0;
        @(negedge clk);
        check("cnt_idle", 32'(cnt3), 32'h0);

`ifdef SIMPLE_OR_STATS_EN
        // hi_cnt through the top level, CNT_W = 3.
        clr = 1'b1; a8 = 8'h00;
        @(negedge clk);
        check("hi_clr0", 32'(hi_cnt8), 32'h0);
        clr = 1'b0; a8 = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("hi_sat_%0d", i), 32'(hi_cnt8), 32'((i > 7) ? 7 : i));
        end
        a8 = 8'h00;
        @(negedge clk);
        check("hi_idle_hold", 32'(hi_cnt8), 32'h7);
        clr = 1'b1;
        @(negedge clk);
        check("hi_clr_end", 32'(hi_cnt8), 32'h0);
        clr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_simple_or

// File: doc/simple_or.md
# simple_or

Bitwise two-input OR primitive for the basic-gates library, used wherever a combinational OR with optional registered and monitoring outputs is needed. The core output `f` is purely combinational (`a | b`) and never depends on clock or reset. Around it sit a one-cycle registered copy, a sticky "ever-high" flag and an optional saturating activity counter, all clocked on `clk`. These support downstream timing closure and on-chip observation.

## Interface
Parameters:
- `WIDTH`, 1, bit width of `a`, `b`, `f`, `f_q` and `f_sticky`.
- `CNT_W`, 16, width of `hi_cnt`; only meaningful with stats compiled in.

Ports:
- `clk`  in  1  single clock; all registers update on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `clr`  in  1  synchronous clear of `f_sticky` and `hi_cnt`.
- `f`  out  WIDTH  combinational `a | b`.
- `f_q`  out  WIDTH  `f` registered once.
- `f_sticky`  out  WIDTH  per-bit OR of all `f` values since the last reset or clear.
- `hi_cnt`  out  CNT_W  count of cycles with any bit of `f` high. Present only with `SIMPLE_OR_STATS_EN`.

## Operation
- `f[i] = a[i] | b[i]` for every bit. Truth table per bit: 00→0, 01→1, 10→1, 11→1.
- `f` is valid with `clk` idle and `rst` at any value, including X.
- `f_q` is set to `f` on every rising edge of `clk`.
- `f_sticky` is set to `f_sticky | f` on every rising edge.
- `clr` high at an edge: `f_sticky` loads 0 and `hi_cnt` loads 0. Clear wins over accumulate in the same cycle, so `f` in that cycle is discarded.
- `hi_cnt` increments by 1 at an edge where `|f` = 1 and `clr` = 0. It saturates at `2^CNT_W - 1` and does not wrap.
- No X-propagation masking: X on `a` or `b` may propagate to `f`.

## Timing
- `f` has zero-cycle latency, combinational from `a` and `b` only.
- `f_q` has one-cycle latency.
- `f_sticky` and `hi_cnt` reflect `f` from the previous edge.
- `rst` asserted immediately drives `f_q`, `f_sticky` and `hi_cnt` to 0, without waiting for a clock edge. `f` is unaffected.
- While `rst` is high, registers hold 0.
- On `rst` deassertion, the first rising edge captures normally.
- Reset mid-count discards the accumulated count.

## Configuration
- `SIMPLE_OR_STATS_EN` defined: the `hi_cnt` port and its saturating counter are compiled in.
- `SIMPLE_OR_STATS_EN` undefined: `hi_cnt` port and logic are absent.
- All other behaviour is identical in both builds.

## Structure
- Package `simple_or_pkg` holds:
  - default constants `SIMPLE_OR_WIDTH_DEF = 1` and `SIMPLE_OR_CNT_W_DEF = 16`;
  - typedef `cnt_t` (logic [CNT_W-1:0]);
  - constant `CNT_MAX` (all ones).
- One sub-module, `simple_or_sat_cnt`:
  - generic saturating up-counter with `inc` and `clr` inputs and async active-high `rst`;
  - instantiated only under `SIMPLE_OR_STATS_EN`.
- The OR itself is a continuous assignment in `simple_or`, not a sub-module.

## Test plan
- Exhaustive truth table, WIDTH=1, no clock, 10 ns per step. Drive a,b = 00,01,10,11 → f = 0,1,1,1 immediately after each change.
- Reset: hold `rst` = 1 with registers previously nonzero → `f_q`, `f_sticky`, `hi_cnt` = 0 before any clock edge. `f` still follows `a | b`.
- Registered path. Drive a=1, b=0 at cycle 0, then a=0, b=0 at cycle 1 → `f_q` = 1 after edge 1 and 0 after edge 2. `f_sticky` stays 1.
- Sticky clear collision. With `f_sticky` = 1, assert `clr` for one cycle with a=1 → `f_sticky` = 0 after that edge. It returns to 1 on the next edge if a remains 1.
- Counter saturation with stats on, CNT_W=3. Hold a=1 for 10 cycles → `hi_cnt` reads 1..7, then stays 7. Then `clr` → 0.
- WIDTH=8. a=0xA5, b=0x5A → f=0xFF. a=0x0F, b=0x00 → f=0x0F, and `f_sticky` accumulates to 0xFF.
